// File: rtl/spi_master_tx.sv
// SPI master transmitter: 12-bit word, LSB first, sclk free-running from a divider.
// cs/mosi update only on sclk falling toggles; frame = 1 setup period + 12 data periods.
module spi_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] din,
  output logic        ready,
  output logic        busy,
  output logic        sclk,
  output logic        cs,
  output logic        mosi,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, SHIFT, GUARD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [3:0]  bit_q, bit_d;
  logic [11:0] sh_q, sh_d;
  logic        tick, fall;

  assign tick  = (div_q == DIV_LAST);
  assign fall  = tick & sclk_q;

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign sclk  = sclk_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;
  assign done  = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    div_d   = tick ? 8'd0 : div_q + 8'd1;
    sclk_d  = tick ? ~sclk_q : sclk_q;
    state_d = state_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d    = din;
        state_d = WAIT;
      end
      WAIT: if (fall) begin
        cs_d    = 1'b0;
        mosi_d  = 1'b0;
        state_d = SETUP;
      end
      SETUP: if (fall) begin
        mosi_d  = sh_q[0];
        sh_d    = {1'b0, sh_q[11:1]};
        bit_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: if (fall) begin
        // bit_q names the bit currently on mosi; end after bit 11 had a full period
        if (bit_q == 4'd11) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          bit_d   = 4'd0;
          state_d = GUARD;
        end else begin
          mosi_d  = sh_q[0];
          sh_d    = {1'b0, sh_q[11:1]};
          bit_d   = bit_q + 4'd1;
        end
      end
      GUARD: if (fall) begin
        if (bit_q == 4'd1) begin
          bit_d   = 4'd0;
          state_d = IDLE;
        end else begin
          bit_d   = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and 1), SPI slave model feeding a scoreboard.
module tb_spi_master_tx;

  typedef struct {int id; int edges; logic first; logic [11:0] data;} frame_t;
  typedef struct {int id; logic [11:0] data;} exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, ready, busy, sclk, cs, mosi, done;
  logic [11:0] din [2];

  int checks = 0;
  int failures = 0;

  frame_t rxq[$];
  exp_t   expq[$];

  int   cyc = 0;
  int   ecnt [2], dones [2], viol [2], lastrise [2], csrise [2], gap [2];
  logic first [2];
  logic [11:0] shr [2];
  logic psclk [2], pcs [2], pmosi [2], pdone [2];
  int   cdiv [2];

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .din(din[0]), .ready(ready[0]), .busy(busy[0]),
    .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .done(done[0]));

  spi_master_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .din(din[1]), .ready(ready[1]), .busy(busy[1]),
    .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .done(done[1]));

  // slave model + continuous protocol watch, sampled on the falling clk edge
  initial begin
    cdiv[0] = 4; cdiv[1] = 1;
    for (int i = 0; i < 2; i++) begin
      ecnt[i] = 0; dones[i] = 0; viol[i] = 0; lastrise[i] = -1; csrise[i] = -1;
      gap[i] = 1000000; first[i] = 1'b0; shr[i] = '0;
      psclk[i] = 1'b0; pcs[i] = 1'b1; pmosi[i] = 1'b0; pdone[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          ecnt[i] = 0; lastrise[i] = -1;
          psclk[i] = 1'b0; pcs[i] = 1'b1; pmosi[i] = 1'b0; pdone[i] = 1'b0;
        end else begin
          if (sclk[i] && !psclk[i]) begin
            if (cs[i] !== pcs[i] || mosi[i] !== pmosi[i]) viol[i]++;
            if (lastrise[i] >= 0 && cyc - lastrise[i] != 2 * cdiv[i]) viol[i]++;
            lastrise[i] = cyc;
            if (!cs[i]) begin
              if (ecnt[i] == 0) first[i] = mosi[i];
              else if (ecnt[i] <= 12) shr[i][ecnt[i]-1] = mosi[i];
              ecnt[i]++;
            end
          end
          if (done[i] && pdone[i]) viol[i]++;
          if (done[i]) dones[i]++;
          if (cs[i] && !pcs[i]) begin
            if (ecnt[i] > 0) rxq.push_back('{i, ecnt[i], first[i], shr[i]});
            ecnt[i] = 0;
            csrise[i] = cyc;
          end
          if (!cs[i] && pcs[i] && csrise[i] >= 0) gap[i] = cyc - csrise[i];
          psclk[i] = sclk[i]; pcs[i] = cs[i]; pmosi[i] = mosi[i]; pdone[i] = done[i];
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [11:0] data);
    start[i] = 1'b1;
    din[i]   = data;
    expq.push_back('{i, data});
    @(negedge clk);
    chk("capture_ready_low", int'(ready[i]), 0);
    chk("capture_busy_high", int'(busy[i]), 1);
    start[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[i] && n < max);
    chk("ready_within_budget", int'(ready[i]), 1);
  endtask

  task automatic check_frame(input string tag);
    exp_t   e;
    frame_t f;
    chk({tag, "_frame_present"}, int'(rxq.size() > 0 && expq.size() > 0), 1);
    if (rxq.size() > 0 && expq.size() > 0) begin
      f = rxq.pop_front();
      e = expq.pop_front();
      chk({tag, "_id"}, f.id, e.id);
      chk({tag, "_edges_cs_low"}, f.edges, 13);
      chk({tag, "_setup_bit"}, int'(f.first), 0);
      chk({tag, "_data"}, int'(f.data), int'(e.data));
    end
  endtask

  initial begin
    int n, d0, d1;
    int rise_n [2];
    rst = 1'b1;
    start = '0;
    din[0] = '0; din[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_sclk", int'(sclk[i]), 0);
      chk("rst_cs", int'(cs[i]), 1);
      chk("rst_mosi", int'(mosi[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_ready", int'(ready[i]), 1);
      chk("rst_busy", int'(busy[i]), 0);
    end

    // first sclk rise comes CLK_DIV cycles after release
    rst = 1'b0;
    rise_n[0] = -1; rise_n[1] = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (rise_n[i] < 0 && sclk[i]) rise_n[i] = k;
    end
    chk("first_rise_div4", rise_n[0], 4);
    chk("first_rise_div1", rise_n[1], 1);

    // single frame 0xA5C
    d0 = dones[0];
    send(0, 12'hA5C);
    wait_ready(0, 200, n);
    check_frame("a5c");
    chk("a5c_done_count", dones[0] - d0, 1);

    // start held: two back-to-back frames
    d0 = dones[0];
    start[0] = 1'b1;
    din[0] = 12'h001;
    expq.push_back('{0, 12'h001});
    @(negedge clk);
    chk("b2b_first_capture", int'(ready[0]), 0);
    din[0] = 12'hFFF;
    expq.push_back('{0, 12'hFFF});
    wait_ready(0, 200, n);
    @(negedge clk);
    chk("b2b_second_capture", int'(ready[0]), 0);
    start[0] = 1'b0;
    wait_ready(0, 200, n);
    check_frame("b2b_001");
    check_frame("b2b_fff");
    chk("b2b_done_count", dones[0] - d0, 2);
    chk("b2b_cs_gap_ge_2_periods", int'(gap[0] >= 16), 1);

    // start while busy is ignored
    d0 = dones[0];
    send(0, 12'h5A3);
    repeat (20) @(negedge clk);
    start[0] = 1'b1;
    din[0] = 12'h123;
    @(negedge clk);
    start[0] = 1'b0;
    wait_ready(0, 200, n);
    repeat (40) @(negedge clk);
    check_frame("busy_ignore");
    chk("busy_ignore_no_extra_frame", rxq.size(), 0);
    chk("busy_ignore_done_count", dones[0] - d0, 1);

    // reset during data bit 5 aborts asynchronously
    d0 = dones[0];
    start[0] = 1'b1;
    din[0] = 12'hFFF;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (ecnt[0] != 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit5", ecnt[0], 6);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_cs_async", int'(cs[0]), 1);
    chk("abort_mosi_async", int'(mosi[0]), 0);
    chk("abort_sclk_async", int'(sclk[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", int'(ready[0]), 1);
    chk("abort_no_done", dones[0] - d0, 0);
    chk("abort_no_frame", rxq.size(), 0);

    // CLK_DIV=1: only the top data bit set, bounded latency
    d1 = dones[1];
    send(1, 12'h800);
    wait_ready(1, 100, n);
    chk("div1_latency_le_33", int'(n + 1 <= 33), 1);
    check_frame("div1_800");
    chk("div1_done_count", dones[1] - d1, 1);

    repeat (10) @(negedge clk);
    chk("protocol_watch_div4", viol[0], 0);
    chk("protocol_watch_div1", viol[1], 0);
    chk("scoreboard_drained", expq.size() + rxq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
